// File: rtl/min_event_logger.sv
// Timestamps every change of the upstream running minimum within a start-triggered session and
// queues {value, timestamp} events in a small FIFO read out over valid/ready.
module min_event_logger #(
  parameter int unsigned TsW   = 8,
  parameter int unsigned Depth = 4,
  parameter int unsigned PtrW  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        min_in_i,
  input  logic              start_i,
  input  logic              rd_ready_i,
  output logic              rd_valid_o,
  output logic [TsW+1:0]    rd_data_o,
  output logic [PtrW:0]     count_o,
  output logic              overflow_o,
  output logic              settled_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StTrack = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e           state_q;
  logic [TsW-1:0]   ts_q;
  logic [1:0]       prev_q;
  logic             first_q;
  logic             busy_q, settled_q;

  logic [TsW+1:0]   mem_q [Depth];
  logic [TsW+1:0]   mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [TsW+1:0]   rd_data_q, rd_data_d;

  logic evt, pop, push, full;

  assign evt  = (state_q == StTrack) && (first_q || (min_in_i != prev_q));
  assign pop  = (cnt_q != '0) && rd_ready_i;
  assign full = (cnt_q == (PtrW+1)'(Depth));
  // A full FIFO still accepts the new event when the head leaves in the same cycle.
  assign push = evt && (!full || pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ts_q      <= '0;
      prev_q    <= 2'b00;
      first_q   <= 1'b0;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q   <= StTrack;
            ts_q      <= '0;
            first_q   <= 1'b1;
            busy_q    <= 1'b1;
            settled_q <= 1'b0;
          end
        end
        StTrack: begin
          prev_q  <= min_in_i;
          first_q <= 1'b0;
          if (ts_q != '1) ts_q <= ts_q + TsW'(1);
          // Zero is terminal upstream, so the session ends even if the event was dropped.
          if (evt && (min_in_i == 2'd0)) begin
            state_q   <= StDone;
            busy_q    <= 1'b0;
            settled_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          settled_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (evt && full && !pop) ovf_d = 1'b1;
    if (push) begin
      mem_d[wptr_d] = {min_in_i, ts_q};
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (pop) rptr_d = rptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PtrW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    // Head is registered so an emptied FIFO keeps presenting the last entry.
    rd_data_d = (cnt_d != '0) ? mem_d[rptr_d] : rd_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q     <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_valid_o = (cnt_q != '0);
  assign rd_data_o  = rd_data_q;
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;
  assign settled_o  = settled_q;
  assign busy_o     = busy_q;

endmodule
